// File: rtl/seq_mult_param_if.sv
// Handshake and data bundle for the sequential shift-add multiplier.
interface seq_mult_param_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 product_zero;

  modport master (
    output start, signed_mode, a_in, b_in,
    input  busy, done, product, product_zero
  );

  modport slave (
    input  start, signed_mode, a_in, b_in,
    output busy, done, product, product_zero
  );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier: magnitudes are multiplied unsigned, the sign
// is applied once at the end, and the full 2*WIDTH product is held until the next op.
module seq_mult_param #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_mult_param_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;
  logic             pzero_q, pzero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  // Magnitude of each operand; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag_c = bus.a_in;
    b_mag_c = bus.b_in;
    if (bus.signed_mode && bus.a_in[WIDTH-1]) a_mag_c = WIDTH'(-bus.a_in);
    if (bus.signed_mode && bus.b_in[WIDTH-1]) b_mag_c = WIDTH'(-bus.b_in);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    pzero_d   = pzero_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = PW'(a_mag_c);
          mplier_d = b_mag_c;
          neg_d    = bus.signed_mode & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
          state_d  = CALC;
        end
      end
      CALC: begin
        if ((cnt_q == CW'(WIDTH)) || (EARLY_EXIT && (mplier_q == '0))) begin
          state_d = SIGN;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      SIGN: begin
        product_d = neg_q ? PW'(-acc_q) : acc_q;
        pzero_d   = (product_d == '0);
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    // The completion pulse is registered off the DONE state, so it appears as the unit returns to IDLE.
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      pzero_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      pzero_q   <= pzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.product      = product_q;
  assign bus.product_zero = pzero_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: two instances (early exit on and off) share stimulus.
module tb_seq_mult_param;

  localparam int unsigned W = 16;

  typedef struct {
    logic [2*W-1:0] p;
    int             due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  seq_mult_param_if #(.WIDTH(W)) b0();
  seq_mult_param_if #(.WIDTH(W)) b1();

  seq_mult_param #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  seq_mult_param #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference product: plain integer multiplication, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sm);
    longint sa, sb, p;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Iterations performed: bit length of |b| with early exit, otherwise always W.
  function automatic int model_k(input logic [W-1:0] b, input logic sm, input bit ee);
    int m, k;
    if (!ee) return W;
    m = sm ? int'($signed(b)) : int'(b);
    if (m < 0) m = -m;
    k = 0;
    while ((m >> k) != 0) k++;
    return k;
  endfunction

  task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    b0.start = st; b0.a_in = a; b0.b_in = b; b0.signed_mode = sm;
    b1.start = st; b1.a_in = a; b1.b_in = b; b1.signed_mode = sm;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((b0.busy || b1.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(b0.busy | b1.busy), 64'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input bit push);
    wait_idle();
    @(negedge clk);
    drive(1'b1, a, b, sm);
    @(negedge clk);
    drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    if (push) begin
      q0.push_back('{model_prod(a, b, sm), cyc + 3 + model_k(b, sm, 1'b1)});
      q1.push_back('{model_prod(a, b, sm), cyc + 3 + model_k(b, sm, 1'b0)});
    end
    chk("busy0_after_start", 64'(b0.busy), 64'd1);
    chk("busy1_after_start", 64'(b1.busy), 64'd1);
  endtask

  task automatic chk_reset_state();
    chk("rst_busy0", 64'(b0.busy), 64'd0);
    chk("rst_done0", 64'(b0.done), 64'd0);
    chk("rst_prod0", 64'(b0.product), 64'd0);
    chk("rst_zero0", 64'(b0.product_zero), 64'd1);
    chk("rst_busy1", 64'(b1.busy), 64'd0);
    chk("rst_prod1", 64'(b1.product), 64'd0);
    chk("rst_zero1", 64'(b1.product_zero), 64'd1);
  endtask

  // Monitor for the early-exit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b0.done) begin
        if (q0.size() == 0) begin
          chk("dut0_unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q0.pop_front();
          chk("dut0_product", 64'(b0.product), 64'(e.p));
          chk("dut0_zero", 64'(b0.product_zero), 64'(e.p == '0));
          chk("dut0_latency", 64'(cyc), 64'(e.due));
        end
      end else if (q0.size() != 0 && cyc > q0[0].due) begin
        e = q0.pop_front();
        chk("dut0_missing_done", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Monitor for the fixed-iteration instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b1.done) begin
        if (q1.size() == 0) begin
          chk("dut1_unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q1.pop_front();
          chk("dut1_product", 64'(b1.product), 64'(e.p));
          chk("dut1_zero", 64'(b1.product_zero), 64'(e.p == '0));
          chk("dut1_latency", 64'(cyc), 64'(e.due));
        end
      end else if (q1.size() != 0 && cyc > q1[0].due) begin
        e = q1.pop_front();
        chk("dut1_missing_done", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1;

    issue(16'd17, 16'd5, 1'b0, 1'b1);
    issue(16'hFFFD, 16'd7, 1'b1, 1'b1);
    issue(16'h8000, 16'h8000, 1'b1, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    issue(16'h1234, 16'h0000, 1'b0, 1'b1);
    issue(16'h0000, 16'h00F3, 1'b0, 1'b1);
    issue(16'hFFFB, 16'h0000, 1'b1, 1'b1);
    issue(16'h7FFF, 16'h8000, 1'b1, 1'b1);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1);

    // Start pulse while busy must be ignored.
    issue(16'hFFFF, 16'h00FF, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'h0003, 16'h0003, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);

    // Reset in the middle of CALC aborts with no product update.
    issue(16'h1234, 16'h8001, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h8001, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom) >> ($urandom % W);
      issue(ra, rb, 1'($urandom), 1'b1);
    end

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
